// File: rtl/mul_div_execute.sv
// Multiply/divide execute unit for R-type M-extension ops.
// mul/mulh finish in one cycle; div/rem use a radix-2 restoring divider
// that runs for DIV_CYCLES iterations and holds the unit busy.
// Optional build macro MUL_DIV_EARLY_OUT_EN: divide-by-zero and signed
// overflow skip the iterative divider and complete in one cycle.
module mul_div_execute #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            issue_valid_i,
    input  logic [4:0]      execute_type_i,
    input  logic [XLEN-1:0] operand1_data_i,
    input  logic [XLEN-1:0] operand2_data_i,
    input  logic [4:0]      rd_in_i,
    input  logic            flush_i,
    output logic            issue_ready_o,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_out_o,
    output logic            busy_o
);

    localparam int unsigned CntW = $clog2(DIV_CYCLES + 1);

    typedef enum logic [1:0] {
        StIdle,
        StDivRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]   rem_q, rem_d;         // partial remainder
    logic [XLEN-1:0]   quo_q, quo_d;         // |dividend| shifted out, quotient shifted in
    logic [XLEN-1:0]   divisor_q, divisor_d; // |divisor|
    logic [XLEN-1:0]   dividend_q, dividend_d;
    logic              is_rem_q, is_rem_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic              div_zero_q, div_zero_d;
    logic [4:0]        rd_tag_q, rd_tag_d;   // tag of the op in flight
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_q, rd_d;

    logic              accept;
    logic [2*XLEN-1:0] prod;
    logic              a_neg, b_neg, b_zero;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [XLEN:0]     rem_shift, diff;
    logic              sub_ok;
    logic [XLEN-1:0]   rem_next, quo_next;
    logic [XLEN-1:0]   q_fix, r_fix, div_final;

    // Status outputs decoded from the current state only
    always_comb begin
        issue_ready_o  = (state_q == StIdle) || (state_q == StDone);
        busy_o         = (state_q == StDivRun);
        result_valid_o = (state_q == StDone);
        result_o       = result_q;
        rd_out_o       = rd_q;
    end

    // Operand preprocessing and the single-cycle multiplier
    always_comb begin
        accept = issue_valid_i && issue_ready_o && !flush_i;
        a_neg  = operand1_data_i[XLEN-1];
        b_neg  = operand2_data_i[XLEN-1];
        b_zero = (operand2_data_i == '0);
        abs_a  = a_neg ? -operand1_data_i : operand1_data_i;
        abs_b  = b_neg ? -operand2_data_i : operand2_data_i;
        // Low 2*XLEN bits of the product of sign-extended operands is the signed product
        prod   = {{XLEN{a_neg}}, operand1_data_i} * {{XLEN{b_neg}}, operand2_data_i};
    end

    // One restoring shift-subtract step plus final sign correction
    always_comb begin
        rem_shift = {rem_q, quo_q[XLEN-1]};
        diff      = rem_shift - {1'b0, divisor_q};
        sub_ok    = !diff[XLEN];
        rem_next  = sub_ok ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
        quo_next  = {quo_q[XLEN-2:0], sub_ok};
        q_fix     = neg_quo_q ? -quo_next : quo_next;
        r_fix     = neg_rem_q ? -rem_next : rem_next;
        if (div_zero_q) begin
            q_fix = '1;
            r_fix = dividend_q;
        end
        div_final = is_rem_q ? r_fix : q_fix;
    end

`ifdef MUL_DIV_EARLY_OUT_EN
    logic ovf;
    logic [XLEN-1:0] early_res;

    // Results for the cases that bypass the iterative divider
    always_comb begin
        ovf = (operand1_data_i == {1'b1, {(XLEN-1){1'b0}}}) && (operand2_data_i == '1);
        if (b_zero) begin
            early_res = (execute_type_i == 5'd3) ? operand1_data_i : '1;
        end else begin
            early_res = (execute_type_i == 5'd3) ? '0 : operand1_data_i;
        end
    end
`endif

    // Next-state logic: flush wins over everything, including a same-cycle accept
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        divisor_d  = divisor_q;
        dividend_d = dividend_q;
        is_rem_d   = is_rem_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        rd_tag_d   = rd_tag_q;
        result_d   = result_q;
        rd_d       = rd_q;

        if (flush_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    state_d = StIdle;
                    if (accept) begin
                        case (execute_type_i)
                            5'd0: begin
                                result_d = prod[XLEN-1:0];
                                rd_d     = rd_in_i;
                                state_d  = StDone;
                            end
                            5'd1: begin
                                result_d = prod[2*XLEN-1:XLEN];
                                rd_d     = rd_in_i;
                                state_d  = StDone;
                            end
                            5'd2, 5'd3: begin
                                is_rem_d   = (execute_type_i == 5'd3);
                                neg_quo_d  = a_neg ^ b_neg;
                                neg_rem_d  = a_neg;
                                div_zero_d = b_zero;
                                dividend_d = operand1_data_i;
                                divisor_d  = abs_b;
                                quo_d      = abs_a;
                                rem_d      = '0;
                                cnt_d      = '0;
                                rd_tag_d   = rd_in_i;
                                state_d    = StDivRun;
`ifdef MUL_DIV_EARLY_OUT_EN
                                if (b_zero || ovf) begin
                                    result_d = early_res;
                                    rd_d     = rd_in_i;
                                    state_d  = StDone;
                                end
`endif
                            end
                            default: begin
                                result_d = '0;
                                rd_d     = rd_in_i;
                                state_d  = StDone;
                            end
                        endcase
                    end
                end
                StDivRun: begin
                    rem_d = rem_next;
                    quo_d = quo_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntW'(DIV_CYCLES - 1)) begin
                        result_d = div_final;
                        rd_d     = rd_tag_q;
                        state_d  = StDone;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            divisor_q  <= '0;
            dividend_q <= '0;
            is_rem_q   <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            rd_tag_q   <= '0;
            result_q   <= '0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            divisor_q  <= divisor_d;
            dividend_q <= dividend_d;
            is_rem_q   <= is_rem_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            rd_tag_q   <= rd_tag_d;
            result_q   <= result_d;
            rd_q       <= rd_d;
        end
    end

endmodule

// File: tb/tb_mul_div_execute.sv
// Self-checking bench for mul_div_execute: directed cases plus random ops
// compared against an arithmetic reference model.
module tb_mul_div_execute;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  execute_type;
    logic [31:0] op1, op2;
    logic [4:0]  rd_in;
    logic        flush;
    logic        issue_ready, result_valid, busy;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int errors = 0;
    int checks = 0;

    mul_div_execute #(
        .XLEN       (32),
        .DIV_CYCLES (32)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .issue_valid_i   (issue_valid),
        .execute_type_i  (execute_type),
        .operand1_data_i (op1),
        .operand2_data_i (op2),
        .rd_in_i         (rd_in),
        .flush_i         (flush),
        .issue_ready_o   (issue_ready),
        .result_valid_o  (result_valid),
        .result_o        (result),
        .rd_out_o        (rd_out),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // RISC-V M-extension semantics using plain 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [4:0] t, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (t)
            5'd0: r = sa * sb;
            5'd1: r = (sa * sb) >>> 32;
            5'd2: r = (b == 0) ? -64'sd1 : sa / sb;
            5'd3: r = (b == 0) ? sa : sa % sb;
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    function automatic int ref_latency(input logic [4:0] t, input logic [31:0] a,
                                       input logic [31:0] b);
        if (t != 5'd2 && t != 5'd3) return 1;
`ifdef MUL_DIV_EARLY_OUT_EN
        if (b == 0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`endif
        return 33;
    endfunction

    // Issue one op, wait for its pulse, check value/tag/latency/busy.
    // Returns in the result_valid cycle so the caller may issue back-to-back.
    task automatic run_op(input string tag, input logic [4:0] t, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input bit poke_busy);
        int lat, busy_n, rdy_bad, exp_lat;
        exp_lat = ref_latency(t, a, b);
        chk({tag, ".ready_before"}, {31'd0, issue_ready}, 32'd1);
        issue_valid = 1'b1; execute_type = t; op1 = a; op2 = b; rd_in = rd;
        tick();
        issue_valid = 1'b0;
        lat = 1; busy_n = 0; rdy_bad = 0;
        while (!result_valid && lat < 40) begin
            if (busy) busy_n++;
            if (issue_ready === busy) rdy_bad++;
            // A competing op offered while busy must be ignored
            if (poke_busy && lat == 5) begin
                issue_valid = 1'b1; execute_type = 5'd0; op1 = 32'd9; op2 = 32'd9; rd_in = 5'd1;
            end else begin
                issue_valid = 1'b0;
            end
            tick();
            lat++;
        end
        issue_valid = 1'b0;
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".result"}, result, ref_model(t, a, b));
        chk({tag, ".rd"}, {27'd0, rd_out}, {27'd0, rd});
        chk({tag, ".busy_cycles"}, busy_n, exp_lat - 1);
        chk({tag, ".ready_vs_busy"}, rdy_bad, 0);
    endtask

    initial begin
        logic [31:0] last;
        int pulses;
        logic [4:0] rt;
        logic [31:0] ra, rb;

        rst = 1'b1; issue_valid = 1'b0; execute_type = '0; op1 = '0; op2 = '0;
        rd_in = '0; flush = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("reset.valid", {31'd0, result_valid}, 32'd0);
        chk("reset.result", result, 32'd0);
        chk("reset.rd", {27'd0, rd_out}, 32'd0);
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.ready", {31'd0, issue_ready}, 32'd1);

        run_op("mul7x-3", 5'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5, 1'b0);
        chk("mul7x-3.const", result, 32'hFFFF_FFEB);
        tick();
        chk("mul.pulse_drop", {31'd0, result_valid}, 32'd0);
        chk("mul.hold", result, 32'hFFFF_FFEB);

        run_op("mulh", 5'd1, 32'h8000_0000, 32'h8000_0000, 5'd7, 1'b0);
        chk("mulh.const", result, 32'h4000_0000);
        run_op("b2b_mul", 5'd0, 32'd2, 32'd3, 5'd8, 1'b0);
        chk("b2b_mul.const", result, 32'd6);
        tick();

        run_op("div-20/3", 5'd2, 32'hFFFF_FFEC, 32'd3, 5'd10, 1'b1);
        chk("div-20/3.const", result, 32'hFFFF_FFFA);
        tick();
        run_op("rem-20/3", 5'd3, 32'hFFFF_FFEC, 32'd3, 5'd11, 1'b0);
        chk("rem-20/3.const", result, 32'hFFFF_FFFE);
        tick();
        run_op("div100/0", 5'd2, 32'd100, 32'd0, 5'd12, 1'b0);
        chk("div100/0.const", result, 32'hFFFF_FFFF);
        tick();
        run_op("rem100/0", 5'd3, 32'd100, 32'd0, 5'd13, 1'b0);
        chk("rem100/0.const", result, 32'd100);
        tick();
        run_op("divneg/0", 5'd2, 32'hFFFF_FF00, 32'd0, 5'd14, 1'b0);
        tick();
        run_op("div_ovf", 5'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b0);
        chk("div_ovf.const", result, 32'h8000_0000);
        tick();
        run_op("rem_ovf", 5'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1'b0);
        tick();
        run_op("unsupported", 5'd7, 32'd5, 32'd6, 5'd17, 1'b0);
        tick();

        // Flush mid-division: the squashed op never produces a pulse
        last = result;
        issue_valid = 1'b1; execute_type = 5'd2; op1 = 32'd1000; op2 = 32'd7; rd_in = 5'd20;
        tick();
        issue_valid = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush.ready", {31'd0, issue_ready}, 32'd1);
        chk("flush.busy", {31'd0, busy}, 32'd0);
        pulses = 0;
        repeat (35) begin
            if (result_valid) pulses++;
            tick();
        end
        chk("flush.no_pulse", pulses, 0);
        chk("flush.result_hold", result, last);
        run_op("mul4x4", 5'd0, 32'd4, 32'd4, 5'd21, 1'b0);
        tick();

        // Flush has priority over a same-cycle accept
        issue_valid = 1'b1; flush = 1'b1; execute_type = 5'd0; op1 = 32'd3; op2 = 32'd3;
        rd_in = 5'd22;
        tick();
        issue_valid = 1'b0; flush = 1'b0;
        chk("flush_vs_accept.valid", {31'd0, result_valid}, 32'd0);
        chk("flush_vs_accept.result", result, 32'd16);

        // Reset mid-division
        issue_valid = 1'b1; execute_type = 5'd2; op1 = 32'd77; op2 = 32'd5; rd_in = 5'd23;
        tick();
        issue_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid.busy", {31'd0, busy}, 32'd0);
        chk("rst_mid.result", result, 32'd0);
        chk("rst_mid.rd", {27'd0, rd_out}, 32'd0);
        chk("rst_mid.valid", {31'd0, result_valid}, 32'd0);
        chk("rst_mid.ready", {31'd0, issue_ready}, 32'd1);

        // Random ops against the reference model, some issued back-to-back
        for (int i = 0; i < 30; i++) begin
            rt = 5'($urandom_range(0, 5));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
            run_op("rand", rt, ra, rb, 5'($urandom_range(0, 31)), 1'b0);
            if ($urandom_range(0, 1) == 0) tick();
        end
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_div_execute.md
Name: mul_div_execute

Overview:
- Multiply/divide execute unit, directly downstream of the instruction decode stage.
- Consumes the decode outputs for R-type M-extension ops (mul_type=1) with forwarded operands, and produces a destination-register result for writeback.
- mul/mulh complete in one cycle.
- div/rem use an iterative radix-2 restoring divider that holds the unit busy until done.

Parameters:
- XLEN, 32, operand/result width.
- DIV_CYCLES, 32, divider iterations; must equal XLEN.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- issue_valid  in  1  decode presents an op with mul_type=1 this cycle
- execute_type  in  5  0=mul, 1=mulh, 2=div, 3=rem; other values are unsupported
- operand1_data  in  XLEN  rs1 value (dividend / multiplicand)
- operand2_data  in  XLEN  rs2 value (divisor / multiplier)
- rd_in  in  5  destination register tag
- flush  in  1  squash the in-flight op (branch redirect)
- issue_ready  out  1  unit can accept an op this cycle
- result_valid  out  1  single-cycle pulse, result/rd_out valid
- result  out  XLEN  computed value
- rd_out  out  5  tag of the completed op
- busy  out  1  divider running (for hazard/forwarding logic)

Behaviour:
- Reset: state=IDLE; result_valid=0, result=0, rd_out=0, busy=0, issue_ready=1, counter=0.
- Accept condition: issue_valid && issue_ready && !flush. Operands and rd are latched on the accept edge.
- issue_ready = (state==IDLE) || (state==DONE). Combinational from state; does not depend on issue_valid.
- States:
  - IDLE: waiting for an accept.
  - DIV_RUN: divider iterating.
  - DONE: outputs result for one cycle.
- mul (type 0):
  - Accept at edge T → result_valid=1 in cycle T+1.
  - result = low 32 bits of the product; signedness is irrelevant.
  - Next state DONE; a new op can be accepted in the same cycle as DONE.
- mulh (type 1):
  - Latency is the same as mul.
  - result = bits [63:32] of the signed×signed 64-bit product.
- div / rem (types 2, 3), signed per RISC-V:
  - On accept, latch |dividend| and |divisor| and the sign flags; counter=0; enter DIV_RUN.
  - Each DIV_RUN cycle performs one shift-subtract step and increments counter.
  - After DIV_CYCLES steps, enter DONE with corrections applied:
    - quotient negated if the operand signs differ;
    - remainder takes the sign of the dividend.
  - Accept at edge T → result_valid in cycle T+33.
  - busy=1 throughout DIV_RUN; issue_ready=0 throughout DIV_RUN.
- Divide by zero: quotient=0xFFFFFFFF; remainder=dividend. Full latency applies (see Optional Feature).
- Overflow (0x80000000 / 0xFFFFFFFF): quotient=0x80000000; remainder=0.
- Unsupported execute_type: op is accepted, result=0, result_valid at T+1, rd_out=rd_in.
- DONE lasts exactly one cycle. Next state is IDLE, or the new op's state if one is accepted in that cycle (back-to-back issue).
- result and rd_out hold their last values after the pulse; only result_valid drops.
- flush:
  - Any state goes to IDLE next edge; no result_valid pulse for the squashed op.
  - flush has priority over a same-cycle accept (no accept while flush=1).
  - flush in the DONE cycle does not suppress the current pulse.
- rst mid-division: aborts immediately; all outputs return to reset values next edge.
- issue_valid while busy: ignored. Decode must hold the op until issue_ready is seen.

Optional Feature:
- Macro: MUL_DIV_EARLY_OUT_EN.
- Defined: divide-by-zero and signed-overflow div/rem skip DIV_RUN and go straight to DONE, so result_valid appears at T+1 with the RISC-V-defined values; busy stays 0.
- Undefined: these cases take the full 33-cycle latency and produce the same values.

Test Plan:
- mul 7×(-3) (0x00000007, 0xFFFFFFFD), rd=5 → result_valid at T+1, result=0xFFFFFFEB, rd_out=5.
- mulh 0x80000000×0x80000000 → T+1 result=0x40000000; back-to-back mul 2×3 accepted in DONE cycle → next cycle result=6.
- div -20/3 (0xFFFFFFEC, 3) → busy 32 cycles, issue_ready=0, result_valid at T+33, result=0xFFFFFFFA; rem of the same operands → 0xFFFFFFFE.
- div 100/0 → 0xFFFFFFFF; rem 100/0 → 100; div 0x80000000/0xFFFFFFFF → 0x80000000. Latency is 33 cycles, or 1 with MUL_DIV_EARLY_OUT_EN.
- div issued, flush at T+10 → no result_valid ever; issue_ready=1 at T+11; following mul 4×4 returns 16 at next cycle.
- rst asserted at T+5 of a division → next cycle busy=0, result=0, rd_out=0, result_valid=0, issue_ready=1.
